multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  rising-edge clock; rst_i  in  1  synchronous reset, active high.
REQ-002 op_i  in  7  opcode field from the instruction register.
REQ-003 zero_i  in  1  ALU zero flag.
REQ-004 mem_ready_i  in  1  memory access complete (present only with MEM_WAIT_EN).
REQ-005 pc_write_o  out  1  PC register enable.
REQ-006 adr_src_o  out  1  memory address mux select: 0 = PC, 1 = Result.
REQ-007 mem_write_o  out  1  data memory write enable.
REQ-008 ir_write_o  out  1  instruction register and OldPC enable.
REQ-009 result_src_o  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-010 alu_src_a_o  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-011 alu_src_b_o  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-012 imm_src_o  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-013 reg_write_o  out  1  register file write enable.
REQ-014 alu_op_o  out  2  ALU decoder class: 00 = add, 01 = sub/compare, 10 = funct-decoded.
REQ-015 illegal_o  out  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-016 instret_o  out  32  count of retired instructions.

Function
REQ-017 The controller SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ and JAL; pc_write_o is the only Mealy output.
REQ-018 Transitions SHALL be:
- FETCH->DECODE.
- DECODE->MEMADR for lw (0000011) or sw (0100011); ->EXECR for R-type (0110011); ->EXECI for I-ALU (0010011); ->BEQ for 1100011; ->JAL for 1101111; ->FETCH for any other opcode.
- MEMADR->MEMREAD for lw, ->MEMWRITE for sw.
- MEMREAD->MEMWB->FETCH.
- MEMWRITE->FETCH.
- EXECR/EXECI->ALUWB->FETCH.
- JAL->ALUWB.
- BEQ->FETCH.
REQ-019 Per-state outputs SHALL be as follows; any field not listed is 0:
- FETCH: adr_src 0, ir_write 1, A 00, B 10, alu_op 00, result_src 10, pc_write 1.
- DECODE: A 01, B 01, alu_op 00.
- MEMADR: A 10, B 01, alu_op 00.
- MEMREAD: adr_src 1, result_src 00.
- MEMWB: result_src 01, reg_write 1.
- MEMWRITE: adr_src 1, mem_write 1.
- EXECR: A 10, B 00, alu_op 10.
- EXECI: A 10, B 01, alu_op 10.
- ALUWB: result_src 00, reg_write 1.
- BEQ: A 10, B 00, alu_op 01, result_src 00, pc_write = zero_i.
- JAL: A 01, B 10, alu_op 00, result_src 00, pc_write 1.
REQ-020 imm_src_o SHALL be combinational from op_i in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
REQ-021 illegal_o SHALL be 1 only in DECODE with an unsupported opcode; in that case no write enable is asserted and instret_o does not increment.
REQ-022 instret_o SHALL increment by 1 on each transition MEMWB->FETCH, MEMWRITE->FETCH, ALUWB->FETCH or BEQ->FETCH, and wrap from FFFFFFFF to 0.
REQ-023 Cycle latency per instruction SHALL be: lw 5, sw 4, R/I 4, beq 3, jal 4.

Reset
REQ-024 While rst_i=1 at a rising edge, state SHALL become FETCH and instret_o SHALL become 0.
REQ-025 While rst_i=1, all write enables (pc_write, ir_write, mem_write, reg_write) and illegal_o SHALL be forced to 0.
REQ-026 Reset asserted in any state, mid-instruction, SHALL abort that instruction without completing its writes; the first cycle after release is FETCH.

Configuration
REQ-027 With MEM_WAIT_EN defined, mem_ready_i SHALL exist and FETCH, MEMREAD and MEMWRITE SHALL hold until mem_ready_i=1.
REQ-028 In a FETCH wait, ir_write and pc_write SHALL be asserted only in the cycle where mem_ready_i=1.
REQ-029 In a MEMWRITE wait, mem_write SHALL stay asserted throughout the wait.
REQ-030 Without MEM_WAIT_EN, the mem_ready_i port SHALL be absent and each of these states SHALL last exactly one cycle.

Structure
REQ-031 Package riscv_ctrl_pkg SHALL hold the state enum, the opcode constants and the select encodings (adr, result, A, B, imm, alu_op).
REQ-032 Sub-module ctrl_imm_deco SHALL implement REQ-020.

Verification
REQ-033 Reset then lw (op 0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in cycle 5, with result_src=01; instret_o=1.
REQ-034 beq with zero_i=1, then beq with zero_i=0 -> pc_write=1 in the BEQ cycle of the first and 0 in the second; each takes 3 cycles.
REQ-035 jal -> states FETCH, DECODE, JAL, ALUWB; pc_write=1 in JAL, reg_write=1 in ALUWB.
REQ-036 op 1111111 -> illegal_o pulses in DECODE, state returns to FETCH, no write enables, instret_o unchanged.
REQ-037 Reset asserted in MEMWRITE -> mem_write_o=0 in that cycle, state FETCH after release, instret_o=0.
REQ-038 MEM_WAIT_EN build, sw with mem_ready_i low for 3 cycles in MEMWRITE -> mem_write_o held high for 4 cycles, then FETCH, instret_o +1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
// Optional feature macro: MEM_WAIT_EN (memory handshake wait states).
package riscv_ctrl_pkg;

  localparam int unsigned OP_W      = 7;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned INSTRET_W = 32;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_e;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  // Memory address mux
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // Result mux
  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  // ALU A mux
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

  // ALU B mux
  localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  // Immediate formats
  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  // ALU decoder class
  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  // Per-state control word, before reset gating
  typedef struct packed {
    logic             pc_write;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic [SEL_W-1:0] result_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic             reg_write;
    logic [SEL_W-1:0] alu_op;
    logic             illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle. mem_ready_i exists only with MEM_WAIT_EN.
interface multicycle_ctrl_if;
  import riscv_ctrl_pkg::*;

  logic [OP_W-1:0]      op_i;
  logic                 zero_i;
`ifdef MEM_WAIT_EN
  logic                 mem_ready_i;
`endif
  logic                 pc_write_o;
  logic                 adr_src_o;
  logic                 mem_write_o;
  logic                 ir_write_o;
  logic [SEL_W-1:0]     result_src_o;
  logic [SEL_W-1:0]     alu_src_a_o;
  logic [SEL_W-1:0]     alu_src_b_o;
  logic [SEL_W-1:0]     imm_src_o;
  logic                 reg_write_o;
  logic [SEL_W-1:0]     alu_op_o;
  logic                 illegal_o;
  logic [INSTRET_W-1:0] instret_o;

`ifdef MEM_WAIT_EN
  modport master (
    input  op_i, zero_i, mem_ready_i,
    output pc_write_o, adr_src_o, mem_write_o, ir_write_o, result_src_o,
           alu_src_a_o, alu_src_b_o, imm_src_o, reg_write_o, alu_op_o,
           illegal_o, instret_o
  );
  modport slave (
    output op_i, zero_i, mem_ready_i,
    input  pc_write_o, adr_src_o, mem_write_o, ir_write_o, result_src_o,
           alu_src_a_o, alu_src_b_o, imm_src_o, reg_write_o, alu_op_o,
           illegal_o, instret_o
  );
`else
  modport master (
    input  op_i, zero_i,
    output pc_write_o, adr_src_o, mem_write_o, ir_write_o, result_src_o,
           alu_src_a_o, alu_src_b_o, imm_src_o, reg_write_o, alu_op_o,
           illegal_o, instret_o
  );
  modport slave (
    output op_i, zero_i,
    input  pc_write_o, adr_src_o, mem_write_o, ir_write_o, result_src_o,
           alu_src_a_o, alu_src_b_o, imm_src_o, reg_write_o, alu_op_o,
           illegal_o, instret_o
  );
`endif

endinterface

// File: rtl/ctrl_imm_deco.sv
// Immediate-format decoder: purely a function of the opcode, valid in every state.
module ctrl_imm_deco
  import riscv_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  op_i,
  output logic [SEL_W-1:0] imm_src_o
);

  // Opcode -> immediate format; unknown opcodes fall back to I
  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_LOAD,
      OP_IALU:   imm_src_o = IMM_I;
      OP_STORE:  imm_src_o = IMM_S;
      OP_BRANCH: imm_src_o = IMM_B;
      OP_JAL:    imm_src_o = IMM_J;
      default:   imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V main controller: Moore FSM, pc_write is the only Mealy output.
// Optional feature macro: MEM_WAIT_EN adds mem_ready_i and stalls FETCH/MEMREAD/MEMWRITE.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.master bus
);

  state_e               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  ctrl_t                ctrl_c;
  logic                 mem_ready_c;

`ifdef MEM_WAIT_EN
  assign mem_ready_c = bus.mem_ready_i;
`else
  assign mem_ready_c = 1'b1;
`endif

  // State and retired-instruction counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state, per-state control word and retirement
  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    ctrl_c    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.adr_src    = ADR_PC;
        ctrl_c.alu_src_a  = SRCA_PC;
        ctrl_c.alu_src_b  = SRCB_FOUR;
        ctrl_c.alu_op     = ALUOP_ADD;
        ctrl_c.result_src = RES_ALURESULT;
        if (mem_ready_c) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl_c.alu_src_a = SRCA_OLDPC;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
        case (bus.op_i)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECR;
          OP_IALU:   state_d = S_EXECI;
          OP_BRANCH: state_d = S_BEQ;
          OP_JAL:    state_d = S_JAL;
          default: begin
            ctrl_c.illegal = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl_c.alu_src_a = SRCA_RD1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
        state_d          = (bus.op_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctrl_c.adr_src    = ADR_RESULT;
        ctrl_c.result_src = RES_ALUOUT;
        if (mem_ready_c) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl_c.result_src = RES_DATA;
        ctrl_c.reg_write  = 1'b1;
        state_d           = S_FETCH;
        instret_d         = instret_q + INSTRET_W'(1);
      end
      S_MEMWRITE: begin
        ctrl_c.adr_src   = ADR_RESULT;
        ctrl_c.mem_write = 1'b1;
        if (mem_ready_c) begin
          state_d   = S_FETCH;
          instret_d = instret_q + INSTRET_W'(1);
        end
      end
      S_EXECR: begin
        ctrl_c.alu_src_a = SRCA_RD1;
        ctrl_c.alu_src_b = SRCB_RD2;
        ctrl_c.alu_op    = ALUOP_FUNCT;
        state_d          = S_ALUWB;
      end
      S_EXECI: begin
        ctrl_c.alu_src_a = SRCA_RD1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_FUNCT;
        state_d          = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.reg_write  = 1'b1;
        state_d           = S_FETCH;
        instret_d         = instret_q + INSTRET_W'(1);
      end
      S_BEQ: begin
        ctrl_c.alu_src_a  = SRCA_RD1;
        ctrl_c.alu_src_b  = SRCB_RD2;
        ctrl_c.alu_op     = ALUOP_SUB;
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.pc_write   = bus.zero_i;
        state_d           = S_FETCH;
        instret_d         = instret_q + INSTRET_W'(1);
      end
      S_JAL: begin
        ctrl_c.alu_src_a  = SRCA_OLDPC;
        ctrl_c.alu_src_b  = SRCB_FOUR;
        ctrl_c.alu_op     = ALUOP_ADD;
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.pc_write   = 1'b1;
        state_d           = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format decode
  ctrl_imm_deco u_imm_deco (
    .op_i      (bus.op_i),
    .imm_src_o (bus.imm_src_o)
  );

  // Write enables and illegal are squashed while reset is held so an aborted
  // instruction never commits anything.
  assign bus.pc_write_o   = ctrl_c.pc_write  & ~rst_i;
  assign bus.ir_write_o   = ctrl_c.ir_write  & ~rst_i;
  assign bus.mem_write_o  = ctrl_c.mem_write & ~rst_i;
  assign bus.reg_write_o  = ctrl_c.reg_write & ~rst_i;
  assign bus.illegal_o    = ctrl_c.illegal   & ~rst_i;
  assign bus.adr_src_o    = ctrl_c.adr_src;
  assign bus.result_src_o = ctrl_c.result_src;
  assign bus.alu_src_a_o  = ctrl_c.alu_src_a;
  assign bus.alu_src_b_o  = ctrl_c.alu_src_b;
  assign bus.alu_op_o     = ctrl_c.alu_op;
  assign bus.instret_o    = instret_q;

endmodule
